// File: rtl/cs_control_input.sv
// rtl/cs_control_input.sv - PS/2 key decode merged with debounced joystick into registered core controls
// Outputs are registered one edge after the key latches and joystick filters they are built from.
module cs_control_input #(
    parameter logic [15:0] DEB_CYCLES = 16'd50000,
    parameter logic [19:0] START_MIN  = 20'd250000
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [64:0] ps2_key,
    input  logic [15:0] joy,
    output logic        m_left,
    output logic        m_right,
    output logic        m_thrust,
    output logic        m_fire,
    output logic        m_start
);

    typedef enum logic {S_IDLE, S_HOLD} state_t;

    logic        r_old_toggle;
    logic        r_key_left, r_key_right, r_key_thrust, r_key_fire, r_key_start;
    logic [4:0]  r_jf;
    logic [15:0] r_deb_cnt [5];
    logic        r_l_prev, r_r_prev, r_s_prev;
    logic        r_last_dir;
    state_t      r_state;
    logic [19:0] r_start_cnt;
    logic        r_m_left, r_m_right, r_m_thrust, r_m_fire, r_m_start;

    logic        w_event, w_pressed, w_ext;
    logic [8:0]  w_code;
    logic [4:0]  w_raw;
    logic        w_l, w_r, w_t, w_f, w_s;
    logic        w_l_rise, w_r_rise, w_s_rise;
    logic        w_last_dir_next;
    state_t      w_state_next;
    logic        w_start_load;
    logic        w_unused_joy;

    assign w_event   = ps2_key[64] != r_old_toggle;
    assign w_pressed = ps2_key[15:8] != 8'hF0;
    assign w_ext     = w_pressed ? (ps2_key[15:8] == 8'hE0) : (ps2_key[23:16] == 8'hE0);
    assign w_code    = (|ps2_key[63:24]) ? 9'd0 : {w_ext, ps2_key[7:0]};

    // Filter bit order: 0 right, 1 left, 2 thrust, 3 fire, 4 start
    assign w_raw        = {joy[6], joy[5], joy[4], joy[1], joy[0]};
    assign w_unused_joy = ^{joy[15:7], joy[3:2]};

    assign w_l = r_key_left   | r_jf[1];
    assign w_r = r_key_right  | r_jf[0];
    assign w_t = r_key_thrust | r_jf[2];
    assign w_f = r_key_fire   | r_jf[3];
    assign w_s = r_key_start  | r_jf[4];

    assign w_l_rise = w_l & ~r_l_prev;
    assign w_r_rise = w_r & ~r_r_prev;
    assign w_s_rise = w_s & ~r_s_prev;
    // last_dir: 1 = right; right wins a simultaneous rise
    assign w_last_dir_next = w_r_rise ? 1'b1 : (w_l_rise ? 1'b0 : r_last_dir);

    always_comb begin
        w_state_next = r_state;
        w_start_load = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_s_rise) begin
                    w_state_next = S_HOLD;
                    w_start_load = 1'b1;
                end
            end
            S_HOLD: begin
                if (w_s_rise) begin
                    w_start_load = 1'b1;
                end else if (r_start_cnt == 20'd0 && !w_s) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        r_old_toggle <= ps2_key[64];
        if (reset) begin
            r_key_left   <= 1'b0;
            r_key_right  <= 1'b0;
            r_key_thrust <= 1'b0;
            r_key_fire   <= 1'b0;
            r_key_start  <= 1'b0;
        end else if (w_event) begin
            if (w_code[7:0] == 8'h6B) r_key_left   <= w_pressed;
            if (w_code[7:0] == 8'h74) r_key_right  <= w_pressed;
            if (w_code == 9'h029)     r_key_thrust <= w_pressed;
            if (w_code == 9'h014)     r_key_fire   <= w_pressed;
            if (w_code == 9'h005)     r_key_start  <= w_pressed;
        end
    end

    always_ff @(posedge clk_sys) begin
        for (int i = 0; i < 5; i++) begin
            if (reset) begin
                r_jf[i]      <= 1'b0;
                r_deb_cnt[i] <= 16'd0;
            end else if (w_raw[i] == r_jf[i]) begin
                r_deb_cnt[i] <= 16'd0;
            end else if (r_deb_cnt[i] == DEB_CYCLES - 16'd1) begin
                r_jf[i]      <= w_raw[i];
                r_deb_cnt[i] <= 16'd0;
            end else begin
                r_deb_cnt[i] <= r_deb_cnt[i] + 16'd1;
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_start_cnt <= 20'd0;
        end else begin
            r_state <= w_state_next;
            if (w_start_load)
                r_start_cnt <= START_MIN - 20'd1;
            else if (r_start_cnt != 20'd0)
                r_start_cnt <= r_start_cnt - 20'd1;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_l_prev   <= 1'b0;
            r_r_prev   <= 1'b0;
            r_s_prev   <= 1'b0;
            r_last_dir <= 1'b0;
            r_m_left   <= 1'b0;
            r_m_right  <= 1'b0;
            r_m_thrust <= 1'b0;
            r_m_fire   <= 1'b0;
            r_m_start  <= 1'b0;
        end else begin
            r_l_prev   <= w_l;
            r_r_prev   <= w_r;
            r_s_prev   <= w_s;
            r_last_dir <= w_last_dir_next;
            if (w_l && w_r) begin
                r_m_left  <= ~w_last_dir_next;
                r_m_right <= w_last_dir_next;
            end else begin
                r_m_left  <= w_l;
                r_m_right <= w_r;
            end
            r_m_thrust <= w_t;
            r_m_fire   <= w_f;
            r_m_start  <= (w_state_next == S_HOLD);
        end
    end

    assign m_left   = r_m_left;
    assign m_right  = r_m_right;
    assign m_thrust = r_m_thrust;
    assign m_fire   = r_m_fire;
    assign m_start  = r_m_start;

endmodule

// File: tb/tb_cs_control_input.sv
// tb/tb_cs_control_input.sv - vector table, start-stretch sequence and random run against a reference model
module tb_cs_control_input;

    localparam int DEB  = 8;
    localparam int SMIN = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [64:0] ps2 = '0;
    logic [15:0] joy = '0;
    logic        tog = 1'b0;
    logic        m_left, m_right, m_thrust, m_fire, m_start;
    wire  [4:0]  outs = {m_left, m_right, m_thrust, m_fire, m_start};

    int checks = 0;
    int errors = 0;

    cs_control_input #(.DEB_CYCLES(16'(DEB)), .START_MIN(20'(SMIN))) dut (
        .clk_sys(clk), .reset(rst), .ps2_key(ps2), .joy(joy),
        .m_left(m_left), .m_right(m_right), .m_thrust(m_thrust),
        .m_fire(m_fire), .m_start(m_start)
    );

    always #5 clk = ~clk;

    // Reference model state: key levels, filtered joystick, mismatch run lengths, hold deadline
    logic       md_tog = 1'b0;
    bit         kl, kr, kt, kf, ks;
    bit   [4:0] jf;
    int         run [5];
    bit         pl, pr, ps, ldr, hold;
    int         rise_e, e;
    logic [4:0] mout = '0;

    task automatic check(input string nm, input logic [4:0] got, input logic [4:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %b expected %b (L R T F S) at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit L, R, T, F, S, ml, mr, pressed, ext;
        bit [4:0] raw;
        e++;
        if (rst) begin
            {kl, kr, kt, kf, ks} = '0;
            jf = '0;
            for (int i = 0; i < 5; i++) run[i] = 0;
            {pl, pr, ps, ldr, hold} = '0;
            md_tog = ps2[64];
            mout = '0;
            return;
        end
        L = kl | jf[1]; R = kr | jf[0]; T = kt | jf[2]; F = kf | jf[3]; S = ks | jf[4];
        if (R && !pr) ldr = 1'b1;
        else if (L && !pl) ldr = 1'b0;
        ml = L; mr = R;
        if (L && R) begin ml = !ldr; mr = ldr; end
        if (S && !ps) begin hold = 1'b1; rise_e = e; end
        else if (hold && !S && e >= rise_e + SMIN) hold = 1'b0;
        mout = {ml, mr, T, F, hold};
        pl = L; pr = R; ps = S;
        if (ps2[64] != md_tog && ps2[63:24] == 40'd0) begin
            pressed = ps2[15:8] != 8'hF0;
            ext = pressed ? (ps2[15:8] == 8'hE0) : (ps2[23:16] == 8'hE0);
            case (ps2[7:0])
                8'h6B: kl = pressed;
                8'h74: kr = pressed;
                8'h29: if (!ext) kt = pressed;
                8'h14: if (!ext) kf = pressed;
                8'h05: if (!ext) ks = pressed;
                default: ;
            endcase
        end
        md_tog = ps2[64];
        raw = {joy[6], joy[5], joy[4], joy[1], joy[0]};
        for (int i = 0; i < 5; i++) begin
            if (raw[i] != jf[i]) begin
                run[i]++;
                if (run[i] == DEB) begin jf[i] = raw[i]; run[i] = 0; end
            end else begin
                run[i] = 0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check("model", outs, mout);
    endtask

    task automatic set_key(input bit flip, input bit pause, input logic [7:0] b2,
                           input logic [7:0] b1, input logic [7:0] cd);
        if (flip) tog = ~tog;
        ps2 = {tog, pause ? 40'h1 : 40'h0, b2, b1, cd};
    endtask

    typedef struct {
        string      name;
        bit         r, f, p;
        logic [7:0] b2, b1, cd;
        logic [15:0] j;
        int         n;
        logic [4:0] exp;
    } vec_t;
    vec_t vecs[$];

    task automatic add(input string nm, input bit r, input bit f, input bit p, input logic [7:0] b2,
                       input logic [7:0] b1, input logic [7:0] cd, input logic [15:0] j,
                       input int n, input logic [4:0] ex);
        vec_t v;
        v.name = nm; v.r = r; v.f = f; v.p = p; v.b2 = b2; v.b1 = b1; v.cd = cd;
        v.j = j; v.n = n; v.exp = ex;
        vecs.push_back(v);
    endtask

    logic [7:0] codes [7] = '{8'h6B, 8'h74, 8'h29, 8'h14, 8'h05, 8'h11, 8'h00};
    logic [7:0] b1s   [3] = '{8'h00, 8'hE0, 8'hF0};

    initial begin
        int cnt;
        repeat (3) tick();
        check("reset_state", outs, 5'b00000);
        rst = 1'b0;

        //   name           rst flip pause b2     b1     code   joy       n  L R T F S
        add("thr_make_lat", 0, 1, 0, 8'h00, 8'h00, 8'h29, 16'h0000, 1, 5'b00000);
        add("thr_make",     0, 0, 0, 8'h00, 8'h00, 8'h29, 16'h0000, 1, 5'b00100);
        add("thr_break",    0, 1, 0, 8'h00, 8'hF0, 8'h29, 16'h0000, 2, 5'b00000);
        add("rt_make_ext",  0, 1, 0, 8'h00, 8'hE0, 8'h74, 16'h0000, 2, 5'b01000);
        add("lt_over_rt",   0, 1, 0, 8'h00, 8'h00, 8'h6B, 16'h0000, 2, 5'b10000);
        add("lt_release",   0, 1, 0, 8'h00, 8'hF0, 8'h6B, 16'h0000, 2, 5'b01000);
        add("rt_break_ext", 0, 1, 0, 8'hE0, 8'hF0, 8'h74, 16'h0000, 2, 5'b00000);
        add("pause_fire",   0, 1, 1, 8'h00, 8'h00, 8'h14, 16'h0000, 2, 5'b00000);
        add("fire_make",    0, 1, 0, 8'h00, 8'h00, 8'h14, 16'h0000, 2, 5'b00010);
        add("fire_break",   0, 1, 0, 8'h00, 8'hF0, 8'h14, 16'h0000, 2, 5'b00000);
        add("brk_no_make",  0, 1, 0, 8'h00, 8'hF0, 8'h29, 16'h0000, 2, 5'b00000);
        add("ext_thr_skip", 0, 1, 0, 8'h00, 8'hE0, 8'h29, 16'h0000, 2, 5'b00000);
        add("joy_lr_wait",  0, 0, 0, 8'h00, 8'h00, 8'h00, 16'h0003, 8, 5'b00000);
        add("joy_lr_rwins", 0, 0, 0, 8'h00, 8'h00, 8'h00, 16'h0003, 1, 5'b01000);
        add("joy_lr_off",   0, 0, 0, 8'h00, 8'h00, 8'h00, 16'h0000, 9, 5'b00000);
        add("fire_glitch7", 0, 0, 0, 8'h00, 8'h00, 8'h00, 16'h0020, 7, 5'b00000);
        add("glitch_gone",  0, 0, 0, 8'h00, 8'h00, 8'h00, 16'h0000, 3, 5'b00000);
        add("fire_hold8",   0, 0, 0, 8'h00, 8'h00, 8'h00, 16'h0020, 8, 5'b00000);
        add("fire_deb_out", 0, 0, 0, 8'h00, 8'h00, 8'h00, 16'h0020, 1, 5'b00010);
        add("fire_joy_off", 0, 0, 0, 8'h00, 8'h00, 8'h00, 16'h0000, 9, 5'b00000);
        add("space_make",   0, 1, 0, 8'h00, 8'h00, 8'h29, 16'h0000, 2, 5'b00100);
        add("rst_w_toggle", 1, 1, 0, 8'h00, 8'h00, 8'h29, 16'h0000, 1, 5'b00000);
        add("post_rst",     0, 0, 0, 8'h00, 8'h00, 8'h29, 16'h0000, 4, 5'b00000);

        foreach (vecs[k]) begin
            rst = vecs[k].r;
            set_key(vecs[k].f, vecs[k].p, vecs[k].b2, vecs[k].b1, vecs[k].cd);
            joy = vecs[k].j;
            repeat (vecs[k].n) tick();
            check(vecs[k].name, outs, vecs[k].exp);
        end
        rst = 1'b0;

        // One-cycle start level via key make then break on the next edge
        set_key(1, 0, 8'h00, 8'h00, 8'h05);
        tick();
        set_key(1, 0, 8'h00, 8'hF0, 8'h05);
        tick();
        check("start_first", {4'b0000, m_start}, 5'b00001);
        cnt = int'(m_start);
        repeat (30) begin
            tick();
            cnt += int'(m_start);
        end
        check("start_len", 5'(cnt), 5'(SMIN));
        check("start_low", {4'b0000, m_start}, 5'b00000);

        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 3) == 0)
                set_key(1, $urandom_range(0, 7) == 0, $urandom_range(0, 1) ? 8'hE0 : 8'h00,
                        b1s[$urandom_range(0, 2)], codes[$urandom_range(0, 6)]);
            if ($urandom_range(0, 15) == 0) joy = 16'($urandom());
            if ($urandom_range(0, 31) == 0) joy = joy ^ 16'h0020;
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
